// File: rtl/sobel_pkg.sv
// Shared types, width helpers and the saturation helper for the Sobel pipeline.
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_L1  = 2'd0,
    MODE_MAX = 2'd1,
    MODE_BIN = 2'd2,
    MODE_GX  = 2'd3
  } mode_e;

  localparam int STAGES = 3;

  // Weighted sum of three taps (1,2,1) needs two extra bits.
  function automatic int sum_w(input int pix_w);
    return pix_w + 2;
  endfunction

  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

  function automatic int mag_w(input int pix_w);
    return pix_w + 2;
  endfunction

  function automatic int l1_w(input int pix_w);
    return pix_w + 3;
  endfunction

  // Clamp v to the largest value representable in w bits.
  function automatic logic [31:0] sat_pix(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sobel_grad_abs.sv
// Signed difference of two weighted sums and its magnitude; one per gradient axis.
module sobel_grad_abs
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  localparam int SUM_W  = sum_w(PIX_W),
  localparam int GRAD_W = grad_w(PIX_W),
  localparam int MAG_W  = mag_w(PIX_W)
) (
  input  logic [SUM_W-1:0] pos_i,
  input  logic [SUM_W-1:0] neg_i,
  output logic [MAG_W-1:0] abs_o
);

  logic signed [GRAD_W-1:0] diff;
  logic        [GRAD_W-1:0] mag;

  always_comb begin
    diff = $signed(GRAD_W'(pos_i)) - $signed(GRAD_W'(neg_i));
    mag  = diff[GRAD_W-1] ? GRAD_W'(-diff) : GRAD_W'(diff);
    // Both sums are non-negative and < 2^SUM_W, so |diff| fits in MAG_W bits.
    abs_o = MAG_W'(mag);
  end

endmodule

// File: rtl/sobel_calc_pipe.sv
// Three-stage Sobel edge engine: weighted sums, gradient magnitudes, mode/saturate.
// Stages collapse bubbles under valid/ready backpressure; edge counter counts emitted hits.
module sobel_calc_pipe
  import sobel_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int OUT_SHIFT = 0,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done_i,
  output logic             ready_o,
  input  logic [PIX_W-1:0] d0_i,
  input  logic [PIX_W-1:0] d1_i,
  input  logic [PIX_W-1:0] d2_i,
  input  logic [PIX_W-1:0] d3_i,
  input  logic [PIX_W-1:0] d4_i,
  input  logic [PIX_W-1:0] d5_i,
  input  logic [PIX_W-1:0] d6_i,
  input  logic [PIX_W-1:0] d7_i,
  input  logic [PIX_W-1:0] d8_i,
  input  logic [1:0]       mode_i,
  input  logic [PIX_W-1:0] thresh_i,
  output logic [PIX_W-1:0] grayscale_o,
  output logic             done_o,
  input  logic             ready_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] edge_cnt_o
);

  localparam int SUM_W = sum_w(PIX_W);
  localparam int MAG_W = mag_w(PIX_W);
  localparam int L1_W  = l1_w(PIX_W);

  typedef struct packed {
    logic [SUM_W-1:0] x_pos;
    logic [SUM_W-1:0] x_neg;
    logic [SUM_W-1:0] y_pos;
    logic [SUM_W-1:0] y_neg;
    mode_e            mode;
    logic [PIX_W-1:0] thr;
  } s1_t;

  typedef struct packed {
    logic [MAG_W-1:0] ax;
    logic [MAG_W-1:0] ay;
    mode_e            mode;
    logic [PIX_W-1:0] thr;
  } s2_t;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             hit;
  } s3_t;

  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  s3_t             s3_q, s3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             en1, en2, en3;
  logic [MAG_W-1:0] ax, ay, mx;
  logic [L1_W-1:0]  l1;
  logic [PIX_W-1:0] s_pix, m_pix, g_pix;
  logic             hit;

  function automatic logic [SUM_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c);
    return SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
  endfunction

  sobel_grad_abs #(.PIX_W(PIX_W)) u_grad_x (
    .pos_i (s1_q.x_pos),
    .neg_i (s1_q.x_neg),
    .abs_o (ax)
  );

  sobel_grad_abs #(.PIX_W(PIX_W)) u_grad_y (
    .pos_i (s1_q.y_pos),
    .neg_i (s1_q.y_neg),
    .abs_o (ay)
  );

  // A stage may load when empty or when the stage after it is taking its contents.
  always_comb begin
    en3 = !vld_pipe_q[3] || ready_i;
    en2 = !vld_pipe_q[2] || en3;
    en1 = !vld_pipe_q[1] || en2;
  end

  // Centre tap d4 has zero weight in both kernels.
  always_comb begin
    s1_d = s1_q;
    if (en1 && done_i) begin
      s1_d.x_pos = wsum(d2_i, d5_i, d8_i);
      s1_d.x_neg = wsum(d0_i, d3_i, d6_i);
      s1_d.y_pos = wsum(d6_i, d7_i, d8_i);
      s1_d.y_neg = wsum(d0_i, d1_i, d2_i);
      s1_d.mode  = mode_e'(mode_i);
      s1_d.thr   = thresh_i;
    end
  end

  always_comb begin
    s2_d = s2_q;
    if (en2 && vld_pipe_q[1]) begin
      s2_d.ax   = ax;
      s2_d.ay   = ay;
      s2_d.mode = s1_q.mode;
      s2_d.thr  = s1_q.thr;
    end
  end

  always_comb begin
    l1    = L1_W'(s2_q.ax) + L1_W'(s2_q.ay);
    mx    = (s2_q.ax > s2_q.ay) ? s2_q.ax : s2_q.ay;
    s_pix = PIX_W'(sat_pix(32'(l1 >> OUT_SHIFT), PIX_W));
    m_pix = PIX_W'(sat_pix(32'(mx >> OUT_SHIFT), PIX_W));
    g_pix = PIX_W'(sat_pix(32'(s2_q.ax >> OUT_SHIFT), PIX_W));
    // Threshold always judges the L1 result, whatever the output mode.
    hit   = s_pix > s2_q.thr;

    s3_d = s3_q;
    if (en3 && vld_pipe_q[2]) begin
      s3_d.hit = hit;
      case (s2_q.mode)
        MODE_L1:  s3_d.pix = s_pix;
        MODE_MAX: s3_d.pix = m_pix;
        MODE_BIN: s3_d.pix = hit ? '1 : '0;
        MODE_GX:  s3_d.pix = g_pix;
        default:  s3_d.pix = s_pix;
      endcase
    end
  end

  always_comb begin
    vld_pipe_d[1] = en1 ? done_i        : vld_pipe_q[1];
    vld_pipe_d[2] = en2 ? vld_pipe_q[1] : vld_pipe_q[2];
    vld_pipe_d[3] = en3 ? vld_pipe_q[2] : vld_pipe_q[3];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (vld_pipe_q[3] && ready_i && s3_q.hit)
      cnt_d = cnt_q + CNT_W'(1);
    if (clr_i)
      cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      cnt_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ready_o     = en1;
  assign done_o      = vld_pipe_q[3];
  assign grayscale_o = s3_q.pix;
  assign edge_cnt_o  = cnt_q;

endmodule
